// File: rtl/step_clock_gen.sv
// Debounced single-step clock generator: one clean press -> one PULSE_CYCLES-wide step_out pulse.
// Optional auto-repeat while the button is held: define STEP_AUTOREPEAT_EN.
module step_clock_gen #(
  parameter int DEBOUNCE_CYCLES = 5000,
  parameter int PULSE_CYCLES    = 5000,
  parameter int REPEAT_CYCLES   = 1000000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       button,
  input  logic       enable,
  output logic       step_out,
  output logic       step_rise,
  output logic [7:0] step_count,
  output logic       busy
);

`ifdef STEP_AUTOREPEAT_EN
  localparam bit AUTOREPEAT = 1'b1;
`else
  localparam bit AUTOREPEAT = 1'b0;
`endif

  localparam logic [23:0] DB_LAST  = 24'(DEBOUNCE_CYCLES - 1);
  localparam logic [23:0] PUL_LAST = 24'(PULSE_CYCLES - 1);
  localparam logic [23:0] REP_LAST = 24'(REPEAT_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE,
    DB_PRESS,
    PULSE,
    HOLD,
    DB_RELEASE
  } state_e;

  state_e      state_q, state_d;
  logic [23:0] cnt_q, cnt_d;
  logic [1:0]  sync_q, sync_d;
  logic        step_out_q, step_out_d;
  logic        step_rise_q, step_rise_d;
  logic [7:0]  step_count_q, step_count_d;
  logic        busy_q, busy_d;
  logic        btn_s;
  logic        cnt_inc;

  assign btn_s = sync_q[1];

  always_comb begin
    sync_d  = {sync_q[0], button};
    state_d = state_q;
    cnt_inc = 1'b0;
    case (state_q)
      IDLE: begin
        if (btn_s && enable) state_d = DB_PRESS;
      end
      DB_PRESS: begin
        if (!btn_s)                 state_d = IDLE;
        else if (cnt_q == DB_LAST)  state_d = PULSE;
        else                        cnt_inc = 1'b1;
      end
      PULSE: begin
        if (cnt_q == PUL_LAST) state_d = btn_s ? HOLD : DB_RELEASE;
        else                   cnt_inc = 1'b1;
      end
      HOLD: begin
        // Without auto-repeat the counter stays parked at zero here.
        if (!btn_s)                                state_d = DB_RELEASE;
        else if (AUTOREPEAT && cnt_q == REP_LAST)  state_d = PULSE;
        else if (AUTOREPEAT)                       cnt_inc = 1'b1;
      end
      DB_RELEASE: begin
        if (btn_s)                  state_d = HOLD;
        else if (cnt_q == DB_LAST)  state_d = IDLE;
        else                        cnt_inc = 1'b1;
      end
      default: state_d = IDLE;
    endcase

    if (state_d != state_q) cnt_d = '0;
    else if (cnt_inc)       cnt_d = cnt_q + 24'd1;
    else                    cnt_d = cnt_q;

    // Outputs are decoded from the next state so step_out is a clean flop output.
    step_out_d   = (state_d == PULSE);
    step_rise_d  = (state_d == PULSE) && (state_q != PULSE);
    step_count_d = step_rise_d ? step_count_q + 8'd1 : step_count_q;
    busy_d       = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      sync_q       <= '0;
      step_out_q   <= 1'b0;
      step_rise_q  <= 1'b0;
      step_count_q <= '0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      sync_q       <= sync_d;
      step_out_q   <= step_out_d;
      step_rise_q  <= step_rise_d;
      step_count_q <= step_count_d;
      busy_q       <= busy_d;
    end
  end

  assign step_out   = step_out_q;
  assign step_rise  = step_rise_q;
  assign step_count = step_count_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_step_clock_gen.sv
// Bench for step_clock_gen: directed scenarios plus random button traffic against a
// timestamp-based phase model of the press/pulse/release behaviour.
module tb_step_clock_gen;
  localparam int D = 4;
  localparam int P = 3;
  localparam int R = 10;
  localparam int PH_IDLE = 0, PH_ARM = 1, PH_PUL = 2, PH_HLD = 3, PH_REL = 4;

`ifdef STEP_AUTOREPEAT_EN
  localparam bit AR = 1'b1;
`else
  localparam bit AR = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       button = 1'b0;
  logic       enable = 1'b1;
  logic       step_out, step_rise, busy;
  logic [7:0] step_count;

  step_clock_gen #(.DEBOUNCE_CYCLES(D), .PULSE_CYCLES(P), .REPEAT_CYCLES(R)) dut (
    .clk(clk), .reset(reset), .button(button), .enable(enable),
    .step_out(step_out), .step_rise(step_rise), .step_count(step_count), .busy(busy)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int cyc = 0;

  // Reference model: phase plus the edge number at which that phase was entered.
  bit m_s1, m_s2;
  int m_ph, m_start, m_cnt;
  bit m_out, m_rise, m_busy;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic model_reset();
    m_s1 = 0; m_s2 = 0; m_ph = PH_IDLE; m_start = cyc; m_cnt = 0;
    m_out = 0; m_rise = 0; m_busy = 0;
  endtask

  task automatic model_step(input bit b, input bit e);
    bit bs;
    int el, nph;
    bs = m_s2; m_s2 = m_s1; m_s1 = b;
    el = cyc - m_start;
    nph = m_ph;
    case (m_ph)
      PH_IDLE: if (bs && e) nph = PH_ARM;
      PH_ARM:  if (!bs) nph = PH_IDLE; else if (el == D) nph = PH_PUL;
      PH_PUL:  if (el == P) nph = bs ? PH_HLD : PH_REL;
      PH_HLD:  if (!bs) nph = PH_REL; else if (AR && el == R) nph = PH_PUL;
      default: if (bs) nph = PH_HLD; else if (el == D) nph = PH_IDLE;
    endcase
    m_rise = (nph == PH_PUL) && (m_ph != PH_PUL);
    if (m_rise) m_cnt = (m_cnt + 1) % 256;
    if (nph != m_ph) m_start = cyc;
    m_ph = nph;
    m_out = (m_ph == PH_PUL);
    m_busy = (m_ph != PH_IDLE);
  endtask

  task automatic check_outputs(input string tag);
    chk({tag, ".step_out"}, 32'(step_out), 32'(m_out));
    chk({tag, ".step_rise"}, 32'(step_rise), 32'(m_rise));
    chk({tag, ".step_count"}, 32'(step_count), 32'(m_cnt));
    chk({tag, ".busy"}, 32'(busy), 32'(m_busy));
  endtask

  // One clock: inputs sampled at the edge feed the model, outputs checked 1ns later.
  task automatic tick(input string tag);
    bit b, e, r;
    b = button; e = enable; r = reset;
    @(posedge clk);
    cyc++;
    if (!r) model_reset();
    else    model_step(b, e);
    #1;
    check_outputs(tag);
  endtask

  task automatic ticks(input int n, input string tag);
    for (int i = 0; i < n; i++) tick(tag);
  endtask

  initial begin
    int c0, first, width, rises, max_busy, hits;

    // Reset asserted with button high
    reset = 0; button = 1; enable = 1;
    model_reset();
    #2;
    check_outputs("rst_hold");
    ticks(3, "rst_clk");
    button = 0; reset = 1;
    ticks(6, "rst_rel");

    // Clean press held 30 cycles: first pulse after E6
    c0 = m_cnt; first = -1; width = 0; rises = 0;
    button = 1;
    for (int i = 0; i < 30; i++) begin
      tick("clean");
      if (step_out === 1'b1) begin
        width++;
        if (first < 0) first = i;
      end
      if (step_rise === 1'b1) rises++;
    end
    button = 0;
    ticks(10, "clean_rel");
    chk("clean.first_edge", 32'(first), 32'd6);
    chk("clean.width", 32'(width), AR ? 32'd6 : 32'd3);
    chk("clean.rises", 32'(rises), AR ? 32'd2 : 32'd1);
    chk("clean.count", 32'(step_count), 32'((c0 + (AR ? 2 : 1)) % 256));

    // Bounce: 1,1,0 pattern never qualifies
    c0 = m_cnt; hits = 0;
    for (int i = 0; i < 20; i++) begin
      button = (i % 3) != 2;
      tick("bounce");
      if (step_out === 1'b1) hits++;
    end
    button = 0;
    ticks(10, "bounce_rel");
    chk("bounce.no_pulse", 32'(hits), 32'd0);
    chk("bounce.count", 32'(step_count), 32'(c0));

    // Bounce during release: back to HOLD, no extra pulse
    c0 = m_cnt;
    button = 1; ticks(12, "relb_press");
    button = 0; ticks(4, "relb_low");
    button = 1; ticks(3, "relb_bounce");
    button = 0; ticks(12, "relb_final");
    chk("relb.count", 32'(step_count), 32'((c0 + 1) % 256));

    // Enable low: press ignored, never busy
    c0 = m_cnt; max_busy = 0;
    enable = 0; button = 1;
    for (int i = 0; i < 15; i++) begin
      tick("en_off");
      if (busy === 1'b1) max_busy = 1;
    end
    button = 0; ticks(6, "en_off_rel");
    chk("en_off.busy", 32'(max_busy), 32'd0);
    chk("en_off.count", 32'(step_count), 32'(c0));

    // Enable dropped in DB_PRESS: sequence completes
    c0 = m_cnt; width = 0;
    enable = 1; button = 1;
    ticks(4, "en_drop_a");
    enable = 0;
    for (int i = 0; i < 10; i++) begin
      tick("en_drop_b");
      if (step_out === 1'b1) width++;
    end
    button = 0; ticks(8, "en_drop_rel");
    enable = 1;
    chk("en_drop.width", 32'(width), 32'd3);
    chk("en_drop.count", 32'(step_count), 32'((c0 + 1) % 256));

    // Wrap: 257 press/release pairs from reset
    reset = 0; ticks(1, "wrap_rst"); reset = 1;
    for (int k = 0; k < 257; k++) begin
      button = 1; ticks(10, "wrap_hi");
      button = 0; ticks(10, "wrap_lo");
    end
    chk("wrap.count", 32'(step_count), 32'd1);

    // Auto-repeat stimulus: held 40 cycles
    reset = 0; ticks(1, "ar_rst"); reset = 1;
    button = 1; ticks(40, "ar_hold");
    button = 0; ticks(10, "ar_rel");
    chk("autorep.count", 32'(step_count), AR ? 32'd3 : 32'd1);

    // Random traffic
    for (int k = 0; k < 150; k++) begin
      button = 1'($urandom_range(0, 1));
      enable = ($urandom_range(0, 7) != 0);
      ticks(int'($urandom_range(1, 14)), "rand");
    end
    button = 0; enable = 1;
    ticks(12, "rand_tail");

    // Asynchronous reset mid-pulse
    button = 1;
    for (int i = 0; i < 20 && !m_out; i++) tick("midp");
    chk("midp.in_pulse", 32'(step_out), 32'd1);
    #3 reset = 0;
    #1;
    chk("midp.step_out", 32'(step_out), 32'd0);
    chk("midp.step_count", 32'(step_count), 32'd0);
    chk("midp.busy", 32'(busy), 32'd0);
    model_reset();
    ticks(1, "midp_clk");
    button = 0; reset = 1;
    ticks(8, "midp_after");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
